// File: rtl/sccomp_dataflow_if.sv
// Data-memory bus between the CPU core (master) and the SoC data RAM (slave).
interface sccomp_dataflow_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic [31:0] rdata;

    modport master (output addr, wdata, we, size, input rdata);
    modport slave  (input addr, wdata, we, size, output rdata);
endinterface

// File: rtl/sccomp_dataflow_top.sv
// MIPS multicycle SoC: instruction ROM, byte-addressable data RAM, and a compact
// fetch/exec/mem core with a register file and CP0 exception support.
module imem #(
    parameter int          DEPTH = 8192,
    parameter logic [31:0] BASE  = 32'h00400000
) (
    input  logic                     clk,
    input  logic [31:0]              addr,
    output logic [31:0]              rdata,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [31:0]              load_data
);
    localparam int IW = $clog2(DEPTH);
    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] offset;

    // Anything below BASE wraps to a huge offset, so one compare covers both ends.
    assign offset = addr - BASE;
    assign rdata  = (offset < 32'(DEPTH * 4)) ? mem[offset[IW+1:2]] : 32'h0;

    always_ff @(posedge clk) begin
        if (load_en) mem[load_idx] <= load_data;
    end
endmodule

module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] regs [0:31];

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end
endmodule

module sccpu #(
    parameter logic [31:0] TEXT_BASE = 32'h00400000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       inst,
    output logic [31:0]       pc,
    sccomp_dataflow_if.master dbus
);
    localparam logic [31:0] EXC_VECTOR = 32'h00400004;
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_t;

    state_t      state, state_next;
    logic [31:0] ir, mem_addr, cp0_status, cp0_cause, cp0_epc;
    logic [31:0] rs_val, rt_val, simm, zimm, alu, pc_plus4, pc_next, cp0_rd, ld_val;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sa, wb_addr, exc_code;
    logic        wb_en, is_load, is_store, exc, eret, commit;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign sa       = ir[10:6];
    assign funct    = ir[5:0];
    assign simm     = {{16{ir[15]}}, ir[15:0]};
    assign zimm     = {16'h0, ir[15:0]};
    assign pc_plus4 = pc + 32'd4;
    assign is_load  = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    assign is_store = op inside {6'h28, 6'h29, 6'h2B};
    assign commit   = (state == S_EXEC && !(is_load || is_store)) || state == S_MEM;

    regfile cpu_ref (.clk(clk), .reset(reset), .we(wb_en), .raddr1(rs), .raddr2(rt),
                     .waddr(wb_addr), .wdata(alu), .rdata1(rs_val), .rdata2(rt_val));

    // The RAM returns the whole aligned word; lane selection and extension happen here.
    assign ld_byte    = dbus.rdata[{mem_addr[1:0], 3'b000} +: 8];
    assign ld_half    = mem_addr[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
    assign dbus.addr  = mem_addr;
    assign dbus.wdata = rt_val;
    assign dbus.we    = (state == S_MEM) && is_store && !reset;

    always_comb begin
        case (op)
            6'h20:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            6'h24:   ld_val = {24'h0, ld_byte};
            6'h21:   ld_val = {{16{ld_half[15]}}, ld_half};
            6'h25:   ld_val = {16'h0, ld_half};
            default: ld_val = dbus.rdata;
        endcase
        case (op)
            6'h23, 6'h2B:        dbus.size = 2'b00;
            6'h21, 6'h25, 6'h29: dbus.size = 2'b01;
            default:             dbus.size = 2'b10;
        endcase
        case (rd)
            5'd12:   cp0_rd = cp0_status;
            5'd13:   cp0_rd = cp0_cause;
            5'd14:   cp0_rd = cp0_epc;
            default: cp0_rd = 32'h0;
        endcase
    end

    always_comb begin
        alu = 32'h0; wb_en = 1'b0; wb_addr = rt; pc_next = pc_plus4;
        exc = 1'b0; exc_code = 5'd0; eret = 1'b0; state_next = S_FETCH;
        case (state)
            S_FETCH: state_next = S_EXEC;
            S_EXEC: begin
                case (op)
                    6'h00: begin
                        wb_addr = rd;
                        wb_en   = 1'b1;
                        case (funct)
                            6'h00: alu = rt_val << sa;
                            6'h02: alu = rt_val >> sa;
                            6'h03: alu = $signed(rt_val) >>> sa;
                            6'h04: alu = rt_val << rs_val[4:0];
                            6'h06: alu = rt_val >> rs_val[4:0];
                            6'h07: alu = $signed(rt_val) >>> rs_val[4:0];
                            6'h08: begin wb_en = 1'b0; pc_next = rs_val; end
                            6'h09: begin alu = pc_plus4; pc_next = rs_val; end
                            6'h0C: begin wb_en = 1'b0; exc = 1'b1; exc_code = 5'd8; end
                            6'h0D: begin wb_en = 1'b0; exc = 1'b1; exc_code = 5'd9; end
                            6'h20, 6'h21: alu = rs_val + rt_val;
                            6'h22, 6'h23: alu = rs_val - rt_val;
                            6'h24: alu = rs_val & rt_val;
                            6'h25: alu = rs_val | rt_val;
                            6'h26: alu = rs_val ^ rt_val;
                            6'h27: alu = ~(rs_val | rt_val);
                            6'h2A: alu = {31'h0, $signed(rs_val) < $signed(rt_val)};
                            6'h2B: alu = {31'h0, rs_val < rt_val};
                            6'h34: begin wb_en = 1'b0; exc = (rs_val == rt_val); exc_code = 5'd13; end
                            default: wb_en = 1'b0;
                        endcase
                    end
                    6'h02: pc_next = {pc_plus4[31:28], ir[25:0], 2'b00};
                    6'h03: begin
                        pc_next = {pc_plus4[31:28], ir[25:0], 2'b00};
                        wb_en = 1'b1; wb_addr = 5'd31; alu = pc_plus4;
                    end
                    6'h04: if (rs_val == rt_val) pc_next = pc_plus4 + {simm[29:0], 2'b00};
                    6'h05: if (rs_val != rt_val) pc_next = pc_plus4 + {simm[29:0], 2'b00};
                    6'h08, 6'h09: begin wb_en = 1'b1; alu = rs_val + simm; end
                    6'h0A: begin wb_en = 1'b1; alu = {31'h0, $signed(rs_val) < $signed(simm)}; end
                    6'h0B: begin wb_en = 1'b1; alu = {31'h0, rs_val < simm}; end
                    6'h0C: begin wb_en = 1'b1; alu = rs_val & zimm; end
                    6'h0D: begin wb_en = 1'b1; alu = rs_val | zimm; end
                    6'h0E: begin wb_en = 1'b1; alu = rs_val ^ zimm; end
                    6'h0F: begin wb_en = 1'b1; alu = {ir[15:0], 16'h0}; end
                    6'h10: begin
                        if (rs == 5'h00) begin
                            wb_en = 1'b1; alu = cp0_rd;
                        end else if (rs == 5'h10 && funct == 6'h18) begin
                            eret = 1'b1; pc_next = cp0_epc;
                        end
                    end
                    default: if (is_load || is_store) state_next = S_MEM;
                endcase
            end
            S_MEM: if (is_load) begin wb_en = 1'b1; alu = ld_val; end
            default: state_next = S_FETCH;
        endcase
        if (exc) pc_next = EXC_VECTOR;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Status keeps a 3-deep mode stack: shift left on exception entry, right on eret.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= TEXT_BASE; ir <= 32'h0; mem_addr <= 32'h0;
            cp0_status <= 32'h0; cp0_cause <= 32'h0; cp0_epc <= 32'h0;
        end else begin
            if (state == S_FETCH) ir <= inst;
            if (state == S_EXEC) mem_addr <= rs_val + simm;
            if (commit) pc <= pc_next;
            if (state == S_EXEC && op == 6'h10 && rs == 5'h04) begin
                case (rd)
                    5'd12:   cp0_status <= rt_val;
                    5'd13:   cp0_cause  <= rt_val;
                    5'd14:   cp0_epc    <= rt_val;
                    default: ;
                endcase
            end
            if (exc) begin
                cp0_epc    <= pc;
                cp0_status <= cp0_status << 5;
                cp0_cause  <= {25'h0, exc_code, 2'b00};
            end else if (eret) begin
                cp0_status <= cp0_status >> 5;
            end
        end
    end
endmodule

module sccomp_dataflow_top #(
    parameter int          IMEM_DEPTH = 8192,
    parameter int          DMEM_DEPTH = 2048,
    parameter logic [31:0] TEXT_BASE  = 32'h00400000,
    parameter logic [31:0] DATA_BASE  = 32'h10010000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    output logic [31:0] inst
);
    localparam int DW = $clog2(DMEM_DEPTH);

    sccomp_dataflow_if bus ();
    logic [31:0] dmem [0:DMEM_DEPTH-1];
    logic [31:0] doff;
    logic        d_in;
    logic [DW-1:0] didx;

    // The load port is reserved for an external program loader and is idle here.
    imem #(.DEPTH(IMEM_DEPTH), .BASE(TEXT_BASE)) imem_inst (
        .clk(clk), .addr(pc), .rdata(inst),
        .load_en(1'b0), .load_idx('0), .load_data(32'h0));

    sccpu #(.TEXT_BASE(TEXT_BASE)) sccpu (
        .clk(clk), .reset(reset), .inst(inst), .pc(pc), .dbus(bus.master));

    assign doff      = bus.addr - DATA_BASE;
    assign d_in      = doff < 32'(DMEM_DEPTH * 4);
    assign didx      = doff[DW+1:2];
    assign bus.rdata = d_in ? dmem[didx] : 32'h0;

    // Little-endian lanes; low address bits pick the lane for sub-word stores.
    always_ff @(posedge clk) begin
        if (bus.we && d_in) begin
            case (bus.size)
                2'b00: dmem[didx] <= bus.wdata;
                2'b01: begin
                    if (bus.addr[1]) dmem[didx][31:16] <= bus.wdata[15:0];
                    else             dmem[didx][15:0]  <= bus.wdata[15:0];
                end
                default: dmem[didx][{bus.addr[1:0], 3'b000} +: 8] <= bus.wdata[7:0];
            endcase
        end
    end
endmodule

// File: tb/tb_sccomp_dataflow_top.sv
// Directed-program bench for the MIPS SoC top: each task runs a short program and
// checks registers, CP0 and memory against hand-computed values.
module tb_sccomp_dataflow_top;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic [31:0] inst;
    int tests = 0;
    int fails = 0;

    sccomp_dataflow_top dut (.clk(clk), .reset(reset), .pc(pc), .inst(inst));

    always #5 clk = ~clk;

    task automatic hold_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to_pc(input logic [31:0] target, input string name);
        int n = 0;
        while (pc !== target && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (pc !== target) begin
            fails++;
            $display("[TB] FAIL %s: pc=%08h, expected %08h (timeout)", name, pc, target);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        dut.imem_inst.mem[0]  = 32'h24010005;
        dut.imem_inst.mem[1]  = 32'h00211021;
        dut.imem_inst.mem[2]  = 32'h3C031001;
        dut.imem_inst.mem[3]  = 32'h24041234;
        dut.imem_inst.mem[4]  = 32'hAC640000;
        dut.imem_inst.mem[5]  = 32'h8C650000;
        dut.imem_inst.mem[6]  = 32'h240600F0;
        dut.imem_inst.mem[7]  = 32'hA0660001;
        dut.imem_inst.mem[8]  = 32'h80670001;
        dut.imem_inst.mem[9]  = 32'h90680001;
        dut.imem_inst.mem[10] = 32'h84690000;
        dut.imem_inst.mem[11] = 32'h240A0007;
        dut.imem_inst.mem[12] = 32'h408A6000;
        dut.imem_inst.mem[13] = 32'h400B6000;
        dut.imem_inst.mem[14] = 32'h0000000C;
        hold_reset();
        tests++;
        if (pc !== 32'h00400000) begin
            fails++; $display("[TB] FAIL reset_pc: got %08h, expected 00400000", pc);
        end
        tests++;
        if (inst !== 32'h24010005) begin
            fails++; $display("[TB] FAIL reset_inst: got %08h, expected 24010005", inst);
        end
        for (int i = 0; i < 32; i++)
            if (dut.sccpu.cpu_ref.regs[i] !== 32'h0) bad++;
        tests++;
        if (bad != 0) begin
            fails++; $display("[TB] FAIL reset_regs: %0d nonzero registers, expected 0", bad);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu();
        run_to_pc(32'h00400008, "alu_commit");
        tests++;
        if (dut.sccpu.cpu_ref.regs[1] !== 32'h5) begin
            fails++; $display("[TB] FAIL alu_r1: got %08h, expected 00000005", dut.sccpu.cpu_ref.regs[1]);
        end
        tests++;
        if (dut.sccpu.cpu_ref.regs[2] !== 32'hA) begin
            fails++; $display("[TB] FAIL alu_r2: got %08h, expected 0000000a", dut.sccpu.cpu_ref.regs[2]);
        end
    endtask

    task automatic test_memory();
        run_to_pc(32'h00400018, "mem_commit");
        tests++;
        if (dut.sccpu.cpu_ref.regs[5] !== 32'h00001234) begin
            fails++; $display("[TB] FAIL lw_r5: got %08h, expected 00001234", dut.sccpu.cpu_ref.regs[5]);
        end
        tests++;
        if (dut.dmem[0] !== 32'h00001234) begin
            fails++; $display("[TB] FAIL sw_word: got %08h, expected 00001234", dut.dmem[0]);
        end
    endtask

    task automatic test_byte_half();
        run_to_pc(32'h0040002C, "bh_commit");
        tests++;
        if (dut.dmem[0] !== 32'h0000F034) begin
            fails++; $display("[TB] FAIL sb_lane1: got %08h, expected 0000f034", dut.dmem[0]);
        end
        tests++;
        if (dut.sccpu.cpu_ref.regs[7] !== 32'hFFFFFFF0) begin
            fails++; $display("[TB] FAIL lb_r7: got %08h, expected fffffff0", dut.sccpu.cpu_ref.regs[7]);
        end
        tests++;
        if (dut.sccpu.cpu_ref.regs[8] !== 32'h000000F0) begin
            fails++; $display("[TB] FAIL lbu_r8: got %08h, expected 000000f0", dut.sccpu.cpu_ref.regs[8]);
        end
        tests++;
        if (dut.sccpu.cpu_ref.regs[9] !== 32'hFFFFF034) begin
            fails++; $display("[TB] FAIL lh_r9: got %08h, expected fffff034", dut.sccpu.cpu_ref.regs[9]);
        end
    endtask

    task automatic test_cp0();
        run_to_pc(32'h00400038, "cp0_commit");
        tests++;
        if (dut.sccpu.cpu_ref.regs[11] !== 32'h7) begin
            fails++; $display("[TB] FAIL mfc0_r11: got %08h, expected 00000007", dut.sccpu.cpu_ref.regs[11]);
        end
        tests++;
        if (inst !== 32'h0000000C) begin
            fails++; $display("[TB] FAIL syscall_fetch: got %08h, expected 0000000c", inst);
        end
        run_to_pc(32'h00400004, "syscall_vector");
        tests++;
        if (dut.sccpu.cp0_epc !== 32'h00400038) begin
            fails++; $display("[TB] FAIL syscall_epc: got %08h, expected 00400038", dut.sccpu.cp0_epc);
        end
        tests++;
        if (dut.sccpu.cp0_status !== 32'h000000E0) begin
            fails++; $display("[TB] FAIL syscall_status: got %08h, expected 000000e0", dut.sccpu.cp0_status);
        end
        tests++;
        if (dut.sccpu.cp0_cause !== 32'h00000020) begin
            fails++; $display("[TB] FAIL syscall_cause: got %08h, expected 00000020", dut.sccpu.cp0_cause);
        end
    endtask

    task automatic test_exception_return();
        reset = 1'b1;
        dut.imem_inst.mem[0] = 32'h0000000C;
        dut.imem_inst.mem[1] = 32'h08100004;
        dut.imem_inst.mem[2] = 32'h00000000;
        dut.imem_inst.mem[3] = 32'h08102000;
        dut.imem_inst.mem[4] = 32'h400D7000;
        dut.imem_inst.mem[5] = 32'h25AD000C;
        dut.imem_inst.mem[6] = 32'h408D7000;
        dut.imem_inst.mem[7] = 32'h42000018;
        hold_reset();
        reset = 1'b0;
        run_to_pc(32'h00400004, "eret_vector");
        tests++;
        if (dut.sccpu.cp0_epc !== 32'h00400000) begin
            fails++; $display("[TB] FAIL eret_epc0: got %08h, expected 00400000", dut.sccpu.cp0_epc);
        end
        run_to_pc(32'h0040000C, "eret_return");
        tests++;
        if (dut.sccpu.cpu_ref.regs[13] !== 32'h0040000C) begin
            fails++; $display("[TB] FAIL eret_r13: got %08h, expected 0040000c", dut.sccpu.cpu_ref.regs[13]);
        end
    endtask

    task automatic test_out_of_range();
        run_to_pc(32'h00408000, "oor_jump");
        tests++;
        if (inst !== 32'h0) begin
            fails++; $display("[TB] FAIL oor_inst: got %08h, expected 00000000", inst);
        end
        run_to_pc(32'h00408004, "oor_nop_advance");
    endtask

    task automatic test_reset_mid_store();
        int n = 0;
        reset = 1'b1;
        dut.imem_inst.mem[0] = 32'h3C031001;
        dut.imem_inst.mem[1] = 32'hAC630004;
        dut.dmem[1] = 32'hDEADBEEF;
        hold_reset();
        reset = 1'b0;
        while (dut.bus.we !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (dut.bus.we !== 1'b1) begin
            fails++; $display("[TB] FAIL store_reach: we=%b, expected 1", dut.bus.we);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (dut.dmem[1] !== 32'hDEADBEEF) begin
            fails++; $display("[TB] FAIL reset_blocks_store: got %08h, expected deadbeef", dut.dmem[1]);
        end
        tests++;
        if (pc !== 32'h00400000) begin
            fails++; $display("[TB] FAIL reset_abort_pc: got %08h, expected 00400000", pc);
        end
        reset = 1'b0;
        run_to_pc(32'h00400008, "store_after_reset");
        tests++;
        if (dut.dmem[1] !== 32'h10010000) begin
            fails++; $display("[TB] FAIL store_word1: got %08h, expected 10010000", dut.dmem[1]);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_memory();
        test_byte_half();
        test_cp0();
        test_exception_return();
        test_out_of_range();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
